usb_frac_bit_timer: RTL and testbench

Parametrised USB bit/byte timing generator for the TX/RX path. It generalises the fixed 8/9-clock bit divider to any system-clock/bit-rate ratio using an integer base divisor plus a fractional accumulator. It adds configurable bits per byte, a bit-stuff hold, packet-start resync and a byte counter. It drives the bit strobe and byte-complete pulse consumed by the shift registers and the TX/RX controllers.

---
 rtl/usb_timer_pkg.sv | 15 +
 rtl/usb_frac_divider.sv | 81 ++++++++
 rtl/usb_frac_bit_timer.sv | 69 ++++++
 tb/tb_usb_frac_bit_timer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usb_timer_pkg.sv
// Shared defaults and width helper for the USB fractional bit timer.
// Optional mid-bit sample strobe is enabled by defining USB_TIMER_MID_STROBE_EN.
package usb_timer_pkg;

   localparam int USB_BASE_DIV  = 8;
   localparam int USB_FRAC_NUM  = 1;
   localparam int USB_FRAC_DEN  = 3;
   localparam int USB_BYTE_BITS = 8;

   // Counter width for a value range of n codes, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/usb_frac_divider.sv
// Integer + fractional bit-period divider producing the bit strobe and an
// optional mid-bit sample strobe (USB_TIMER_MID_STROBE_EN).
module usb_frac_divider
   import usb_timer_pkg::*;
#(
   parameter int BASE_DIV = USB_BASE_DIV,
   parameter int FRAC_NUM = USB_FRAC_NUM,
   parameter int FRAC_DEN = USB_FRAC_DEN
) (
   input  logic clk,
   input  logic rst,
   input  logic timer_en,
   input  logic sync,
   output logic tick,
   output logic bit_strobe,
   output logic sample_strobe
);

   localparam int DIV_W = cnt_width(BASE_DIV + 2);
   localparam int ACC_W = cnt_width(FRAC_DEN + 1);
   localparam logic [DIV_W-1:0] BASE_C = DIV_W'(BASE_DIV);
   localparam logic [ACC_W:0]   NUM_C  = (ACC_W+1)'(FRAC_NUM);
   localparam logic [ACC_W:0]   DEN_C  = (ACC_W+1)'(FRAC_DEN);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] period;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_sum;
   logic [ACC_W:0]   acc_nxt;
   logic             ext;
   logic             wrap;
   logic             carry;
   logic             at_end;

   // wrap remembers that the last enabled cycle ended a bit, so the count
   // restarts at 1 even if timer_en dropped right after the strobe.
   assign period  = BASE_C + DIV_W'(ext);
   assign cnt_nxt = wrap ? DIV_W'(1) : div_cnt + DIV_W'(1);
   assign at_end  = (cnt_nxt == period);
   assign tick    = timer_en & ~sync & at_end;

   assign acc_sum = {1'b0, acc} + NUM_C;
   assign carry   = (acc_sum >= DEN_C);
   assign acc_nxt = carry ? (acc_sum - DEN_C) : acc_sum;

   always_ff @(posedge clk) begin
      if (rst || sync) begin
         div_cnt    <= '0;
         acc        <= '0;
         ext        <= 1'b0;
         wrap       <= 1'b0;
         bit_strobe <= 1'b0;
      end else if (timer_en) begin
         div_cnt    <= cnt_nxt;
         wrap       <= at_end;
         bit_strobe <= at_end;
         if (at_end) begin
            acc <= ACC_W'(acc_nxt);
            ext <= carry;
         end
      end else begin
         bit_strobe <= 1'b0;
      end
   end

`ifdef USB_TIMER_MID_STROBE_EN
   localparam logic [DIV_W-1:0] MID_C = DIV_W'(BASE_DIV / 2);

   always_ff @(posedge clk) begin
      if (rst || sync) begin
         sample_strobe <= 1'b0;
      end else begin
         sample_strobe <= timer_en && (cnt_nxt == MID_C);
      end
   end
`else
   assign sample_strobe = 1'b0;
`endif

endmodule

// File: rtl/usb_frac_bit_timer.sv
// USB bit/byte timing generator: fractional divider plus bit/byte counters,
// stuffed-bit hold and packet-start resync. Macro: USB_TIMER_MID_STROBE_EN.
module usb_frac_bit_timer
   import usb_timer_pkg::*;
#(
   parameter int BASE_DIV   = USB_BASE_DIV,
   parameter int FRAC_NUM   = USB_FRAC_NUM,
   parameter int FRAC_DEN   = USB_FRAC_DEN,
   parameter int BYTE_BITS  = USB_BYTE_BITS,
   parameter int BYTE_CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         timer_en,
   input  logic                         sync,
   input  logic                         stuff_hold,
   output logic                         bit_strobe,
   output logic                         byte_done,
   output logic [$clog2(BYTE_BITS)-1:0] bit_idx,
   output logic [BYTE_CNT_W-1:0]        byte_cnt,
   output logic                         sample_strobe
);

   localparam int IDX_W = $clog2(BYTE_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_BITS - 1);

   if ((FRAC_DEN < 1) || (FRAC_NUM < 0) || (FRAC_NUM >= FRAC_DEN) ||
       (BASE_DIV < 2) || (BYTE_BITS < 2)) begin : g_bad_params
      $error("usb_frac_bit_timer: illegal parameters (need 0<=FRAC_NUM<FRAC_DEN, BASE_DIV>=2, BYTE_BITS>=2)");
   end

   logic tick;

   usb_frac_divider #(
      .BASE_DIV (BASE_DIV),
      .FRAC_NUM (FRAC_NUM),
      .FRAC_DEN (FRAC_DEN)
   ) u_div (
      .clk           (clk),
      .rst           (rst),
      .timer_en      (timer_en),
      .sync          (sync),
      .tick          (tick),
      .bit_strobe    (bit_strobe),
      .sample_strobe (sample_strobe)
   );

   // Counters advance on the same edge that raises bit_strobe, so byte_done
   // and the updated counts appear together with the completing strobe.
   always_ff @(posedge clk) begin
      if (rst || sync) begin
         bit_idx   <= '0;
         byte_cnt  <= '0;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (tick && !stuff_hold) begin
            if (bit_idx == LAST_IDX) begin
               bit_idx   <= '0;
               byte_cnt  <= byte_cnt + BYTE_CNT_W'(1);
               byte_done <= 1'b1;
            end else begin
               bit_idx <= bit_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_frac_bit_timer.sv
// Bench for usb_frac_bit_timer: default and 4/0/4 configurations checked against
// a closed-form bit-end model, directed scenarios then randomized traffic.
module tb_usb_frac_bit_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, timer_en, sync, stuff_hold;
   logic bs0, bd0, ss0, bs1, bd1, ss1;
   logic [2:0] idx0;
   logic [1:0] idx1;
   logic [7:0] bc0, bc1;

   usb_frac_bit_timer dut0 (
      .clk(clk), .rst(rst), .timer_en(timer_en), .sync(sync), .stuff_hold(stuff_hold),
      .bit_strobe(bs0), .byte_done(bd0), .bit_idx(idx0), .byte_cnt(bc0), .sample_strobe(ss0)
   );

   usb_frac_bit_timer #(.BASE_DIV(4), .FRAC_NUM(0), .FRAC_DEN(1), .BYTE_BITS(4), .BYTE_CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .timer_en(timer_en), .sync(sync), .stuff_hold(stuff_hold),
      .bit_strobe(bs1), .byte_done(bd1), .bit_idx(idx1), .byte_cnt(bc1), .sample_strobe(ss1)
   );

   int checks = 0;
   int failures = 0;
   int abs_cnt = 0;

   int m_base[2] = '{8, 4};
   int m_num[2]  = '{1, 0};
   int m_den[2]  = '{3, 1};
   int m_bb[2]   = '{8, 4};
   int en_cnt[2], bits[2], unheld[2];
   bit e_bs[2], e_bd[2], e_ss[2];

   // Enabled-cycle count at which bit k ends: every bit is BASE long, and bit k
   // gets one extra cycle for each fractional carry produced by bits 1..k-1.
   function automatic int bit_end(input int d, input int k);
      if (k == 0) return 0;
      return k * m_base[d] + ((k - 1) * m_num[d]) / m_den[d];
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         e_bs[d] = 1'b0; e_bd[d] = 1'b0; e_ss[d] = 1'b0;
         if (rst || sync) begin
            en_cnt[d] = 0; bits[d] = 0; unheld[d] = 0;
         end else if (timer_en) begin
            en_cnt[d]++;
`ifdef USB_TIMER_MID_STROBE_EN
            if (en_cnt[d] - bit_end(d, bits[d]) == m_base[d] / 2) e_ss[d] = 1'b1;
`endif
            if (en_cnt[d] == bit_end(d, bits[d] + 1)) begin
               e_bs[d] = 1'b1;
               bits[d]++;
               if (!stuff_hold) begin
                  unheld[d]++;
                  if (unheld[d] % m_bb[d] == 0) e_bd[d] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic en, input logic sy, input logic sh);
      timer_en = en; sync = sy; stuff_hold = sh;
      @(posedge clk);
      model_edge();
      #1;
      if (sy || rst) abs_cnt = 0; else abs_cnt++;
      chk("bs0", 32'(bs0), 32'(e_bs[0]));
      chk("bd0", 32'(bd0), 32'(e_bd[0]));
      chk("ss0", 32'(ss0), 32'(e_ss[0]));
      chk("idx0", 32'(idx0), 32'(unheld[0] % m_bb[0]));
      chk("bc0", 32'(bc0), 32'((unheld[0] / m_bb[0]) % 256));
      chk("bs1", 32'(bs1), 32'(e_bs[1]));
      chk("bd1", 32'(bd1), 32'(e_bd[1]));
      chk("ss1", 32'(ss1), 32'(e_ss[1]));
      chk("idx1", 32'(idx1), 32'(unheld[1] % m_bb[1]));
      chk("bc1", 32'(bc1), 32'((unheld[1] / m_bb[1]) % 256));
   endtask

   int strobe_at[$];
   int exp_at[7] = '{8, 16, 24, 33, 41, 49, 58};
   int bd_at, idx_at25, first_at, n_bs1, n_bd1, n_ss1;

   initial begin
      rst = 1'b1; timer_en = 1'b0; sync = 1'b0; stuff_hold = 1'b0;
      step(1, 0, 0);
      step(1, 0, 0);
      chk("rst_bs", 32'(bs0), 0);
      chk("rst_idx", 32'(idx0), 0);
      chk("rst_bc", 32'(bc0), 0);
      rst = 1'b0;

      // Continuous run from reset: strobe sequence and first byte.
      bd_at = -1;
      for (int i = 0; i < 66; i++) begin
         step(1, 0, 0);
         if (bs0) strobe_at.push_back(en_cnt[0]);
         if (bd0 && bd_at < 0) bd_at = en_cnt[0];
      end
      chk("strobe_count", 32'(strobe_at.size()), 8);
      for (int i = 0; i < 7; i++)
         chk("strobe_at", 32'((i < strobe_at.size()) ? strobe_at[i] : -1), 32'(exp_at[i]));
      chk("byte_done_at", 32'(bd_at), 66);
      chk("byte_cnt_after", 32'(bc0), 1);
      chk("idx_after", 32'(idx0), 0);

      // Stuffed third bit pushes the byte out to the ninth strobe.
      step(1, 1, 0);
      bd_at = -1; idx_at25 = -1;
      for (int i = 0; i < 80; i++) begin
         step(1, 0, (en_cnt[0] + 1 == 24) || (en_cnt[0] + 1 == 25));
         if (bd0 && bd_at < 0) bd_at = en_cnt[0];
         if (en_cnt[0] == 25) idx_at25 = idx0;
      end
      chk("held_byte_done_at", 32'(bd_at), 74);
      chk("held_idx", 32'(idx_at25), 2);

      // Five-cycle enable gap after cycle 20 delays the third strobe to 29.
      step(1, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      first_at = -1;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (bs0 && first_at < 0) first_at = abs_cnt;
      end
      chk("gap_strobe_at", 32'(first_at), 29);

      // Sync on the edge that would raise the fourth strobe.
      for (int i = 0; i < 40; i++) begin
         if (en_cnt[0] + 1 == bit_end(0, bits[0] + 1)) break;
         step(1, 0, 0);
      end
      chk("pre_sync_idx", 32'(idx0), 3);
      step(1, 1, 0);
      chk("sync_bs", 32'(bs0), 0);
      chk("sync_bd", 32'(bd0), 0);
      chk("sync_idx", 32'(idx0), 0);
      chk("sync_bc", 32'(bc0), 0);
      first_at = -1;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (bs0 && first_at < 0) first_at = abs_cnt;
      end
      chk("post_sync_strobe_at", 32'(first_at), 8);

      // Small integer configuration: bit every 4, byte every 16.
      step(1, 1, 0);
      n_bs1 = 0; n_bd1 = 0; n_ss1 = 0;
      for (int i = 0; i < 64; i++) begin
         step(1, 0, 0);
         n_bs1 += int'(bs1); n_bd1 += int'(bd1); n_ss1 += int'(ss1);
      end
      chk("cfg1_strobes", 32'(n_bs1), 16);
      chk("cfg1_bytes", 32'(n_bd1), 4);
`ifdef USB_TIMER_MID_STROBE_EN
      chk("cfg1_samples", 32'(n_ss1), 16);
`else
      chk("cfg1_samples", 32'(n_ss1), 0);
`endif

      // Randomized enable, stuffing and resync traffic.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 8) != 0, ($urandom % 150) == 0, ($urandom % 6) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
